// File: rtl/iq_stream_splitter.sv
// ---------------------------------------------------------------------------
// iq_stream_splitter
//
// Splits an AXI-Stream of interleaved I/Q words into two independent
// half-width channel streams (I and Q), each buffered by its own FIFO.
// Every accepted input beat is written into both FIFOs in the same cycle;
// the two channels then drain independently under their own tready.
//
// Extraction modes (latched on the first beat of each packet):
//   mode 0 : bit-interleaved, even bits -> Q, odd bits -> I
//   mode 1 : half-split, low half -> Q, high half -> I
//   swap   : exchanges the I and Q destinations after extraction
//
// Ports
//   aclk, sreset                      clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast  input stream
//   cfg_mode, cfg_swap                extraction configuration
//   i_tdata/tvalid/tready/tlast       I channel output stream
//   q_tdata/tvalid/tready/tlast       Q channel output stream
//   i_burst_last, q_burst_last        last beat of the last packet of a burst
//   packet_count                      index of the packet being accepted
// ---------------------------------------------------------------------------
module iq_stream_splitter #(
    parameter int TDATA_WIDTH = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int BURST_SIZE  = 2
) (
    input  logic                            aclk,
    input  logic                            sreset,
    input  logic [TDATA_WIDTH-1:0]          s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic                            cfg_mode,
    input  logic                            cfg_swap,
    output logic [TDATA_WIDTH/2-1:0]        i_tdata,
    output logic                            i_tvalid,
    input  logic                            i_tready,
    output logic                            i_tlast,
    output logic                            i_burst_last,
    output logic [TDATA_WIDTH/2-1:0]        q_tdata,
    output logic                            q_tvalid,
    input  logic                            q_tready,
    output logic                            q_tlast,
    output logic                            q_burst_last,
    output logic [$clog2(BURST_SIZE)-1:0]   packet_count
);

    localparam int HW  = TDATA_WIDTH / 2;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PCW = $clog2(BURST_SIZE);
    localparam int EW  = HW + 2;

    typedef enum logic {
        IDLE,
        IN_PACKET
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic               swap_q, swap_d;
    logic [PCW-1:0]     packet_count_q, packet_count_d;

    // One shared write pointer: both FIFOs are always written together.
    // Pointers carry one extra bit so full and empty can be told apart.
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        i_rd_ptr_q, i_rd_ptr_d;
    logic [AW:0]        q_rd_ptr_q, q_rd_ptr_d;

    // Entry layout: {burst_last, tlast, data}
    logic [EW-1:0]      i_mem [FIFO_DEPTH];
    logic [EW-1:0]      q_mem [FIFO_DEPTH];

    logic [AW:0]        i_count, q_count;
    logic               i_full, q_full, i_empty, q_empty;
    logic               accept;
    logic               eff_mode, eff_swap;
    logic               burst_last_in;
    logic [HW-1:0]      ext_i, ext_q, bit_i, bit_q;
    logic [EW-1:0]      i_entry_in, q_entry_in;
    logic [EW-1:0]      i_head, q_head;
    logic               i_pop, q_pop;

    // Occupancy and status flags derive purely from registered pointers,
    // so input readiness never depends on a same-cycle pop.
    always_comb begin
        i_count = wr_ptr_q - i_rd_ptr_q;
        q_count = wr_ptr_q - q_rd_ptr_q;
        i_full  = (i_count == (AW+1)'(FIFO_DEPTH));
        q_full  = (q_count == (AW+1)'(FIFO_DEPTH));
        i_empty = (i_count == '0);
        q_empty = (q_count == '0);
    end

    // Input handshake and channel outputs. Valid/last outputs are forced low
    // during reset so nothing is presented while buffered state is cleared.
    always_comb begin
        s_axis_tready = !sreset && !i_full && !q_full;
        accept        = s_axis_tvalid && s_axis_tready;

        i_head        = i_mem[i_rd_ptr_q[AW-1:0]];
        q_head        = q_mem[q_rd_ptr_q[AW-1:0]];

        i_tvalid      = !sreset && !i_empty;
        q_tvalid      = !sreset && !q_empty;
        i_tdata       = i_head[HW-1:0];
        q_tdata       = q_head[HW-1:0];
        i_tlast       = i_tvalid && i_head[HW];
        q_tlast       = q_tvalid && q_head[HW];
        i_burst_last  = i_tvalid && i_head[HW+1];
        q_burst_last  = q_tvalid && q_head[HW+1];

        i_pop         = i_tvalid && i_tready;
        q_pop         = q_tvalid && q_tready;

        packet_count  = packet_count_q;
    end

    // The first beat of a packet uses the live cfg inputs (they are being
    // latched on that same beat); later beats use the latched copy.
    always_comb begin
        eff_mode = (state_q == IDLE) ? cfg_mode : mode_q;
        eff_swap = (state_q == IDLE) ? cfg_swap : swap_q;

        bit_i = '0;
        bit_q = '0;
        for (int j = 0; j < HW; j++) begin
            bit_q[j] = s_axis_tdata[2*j];
            bit_i[j] = s_axis_tdata[2*j+1];
        end

        if (eff_mode) begin
            ext_i = s_axis_tdata[TDATA_WIDTH-1:HW];
            ext_q = s_axis_tdata[HW-1:0];
        end else begin
            ext_i = bit_i;
            ext_q = bit_q;
        end

        burst_last_in = s_axis_tlast && (packet_count_q == PCW'(BURST_SIZE-1));

        if (eff_swap) begin
            i_entry_in = {burst_last_in, s_axis_tlast, ext_q};
            q_entry_in = {burst_last_in, s_axis_tlast, ext_i};
        end else begin
            i_entry_in = {burst_last_in, s_axis_tlast, ext_i};
            q_entry_in = {burst_last_in, s_axis_tlast, ext_q};
        end
    end

    // Next-state logic: packet FSM, cfg latch, packet counter and pointers.
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        swap_d         = swap_q;
        packet_count_d = packet_count_q;
        wr_ptr_d       = wr_ptr_q;
        i_rd_ptr_d     = i_rd_ptr_q;
        q_rd_ptr_d     = q_rd_ptr_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);

            if (state_q == IDLE) begin
                mode_d = cfg_mode;
                swap_d = cfg_swap;
            end

            if (s_axis_tlast) begin
                state_d = IDLE;
                if (packet_count_q == PCW'(BURST_SIZE-1)) begin
                    packet_count_d = '0;
                end else begin
                    packet_count_d = packet_count_q + PCW'(1);
                end
            end else begin
                state_d = IN_PACKET;
            end
        end

        if (i_pop) begin
            i_rd_ptr_d = i_rd_ptr_q + (AW+1)'(1);
        end
        if (q_pop) begin
            q_rd_ptr_d = q_rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (sreset) begin
            state_q        <= IDLE;
            mode_q         <= 1'b0;
            swap_q         <= 1'b0;
            packet_count_q <= '0;
            wr_ptr_q       <= '0;
            i_rd_ptr_q     <= '0;
            q_rd_ptr_q     <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            swap_q         <= swap_d;
            packet_count_q <= packet_count_d;
            wr_ptr_q       <= wr_ptr_d;
            i_rd_ptr_q     <= i_rd_ptr_d;
            q_rd_ptr_q     <= q_rd_ptr_d;
        end
    end

    // Storage has no reset; validity is tracked entirely by the pointers.
    // accept is already held low during reset via s_axis_tready.
    always_ff @(posedge aclk) begin
        if (accept) begin
            i_mem[wr_ptr_q[AW-1:0]] <= i_entry_in;
            q_mem[wr_ptr_q[AW-1:0]] <= q_entry_in;
        end
    end

endmodule

// File: doc/iq_stream_splitter.md
IQ_STREAM_SPLITTER -- requirements
Module: iq_stream_splitter

Interface
REQ-001 The module SHALL have a parameter TDATA_WIDTH, default 64, giving the input word width; it must be even and >=4.
REQ-002 The module SHALL have a parameter FIFO_DEPTH, default 4, giving the entries per channel FIFO; it must be a power of 2 and >=2.
REQ-003 The module SHALL have a parameter BURST_SIZE, default 2, giving the packets per burst; it must be >=2.
REQ-004 Port aclk, input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-005 Port sreset, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port s_axis_tdata, input, TDATA_WIDTH: interleaved I/Q word.
REQ-007 Port s_axis_tvalid, input, 1 bit; port s_axis_tready, output, 1 bit; port s_axis_tlast, input, 1 bit: end of packet.
REQ-008 Port cfg_mode, input, 1 bit: 0 = bit-interleaved (even bits to Q, odd bits to I); 1 = half-split (low half to Q, high half to I).
REQ-009 Port cfg_swap, input, 1 bit: 1 exchanges the I and Q destinations after extraction.
REQ-010 Ports i_tdata and q_tdata, output, TDATA_WIDTH/2 each: channel data.
REQ-011 Ports i_tvalid and q_tvalid, output, 1 bit each; ports i_tready and q_tready, input, 1 bit each.
REQ-012 Ports i_tlast and q_tlast, output, 1 bit each: last beat of a packet.
REQ-013 Ports i_burst_last and q_burst_last, output, 1 bit each: last beat of the last packet of a burst.
REQ-014 Port packet_count, output, $clog2(BURST_SIZE) bits: index of the packet currently being accepted.

Function
REQ-015 A beat SHALL be accepted when s_axis_tvalid && s_axis_tready.
- Each accepted beat is written to both the I FIFO and the Q FIFO in the same cycle.
REQ-016 s_axis_tready SHALL be 1 only when sreset=0 and neither FIFO is full.
- It depends on registered full flags only.
- A same-cycle read of a full FIFO does not raise ready.
REQ-017 In mode 0, Q[j] SHALL equal tdata[2j] and I[j] SHALL equal tdata[2j+1], for j = 0..TDATA_WIDTH/2-1.
REQ-018 In mode 1, Q SHALL equal tdata[W/2-1:0] and I SHALL equal tdata[W-1:W/2].
REQ-019 The FSM SHALL have the states IDLE and IN_PACKET.
- IDLE->IN_PACKET: on an accepted beat with tlast=0.
- IN_PACKET->IDLE: on an accepted beat with tlast=1.
- An accepted beat with tlast=1 in IDLE (single-beat packet) stays in IDLE.
REQ-020 cfg_mode and cfg_swap SHALL be latched on the first accepted beat of each packet (any accept in IDLE).
- That beat and every later beat of the packet use the latched values.
- Changes to cfg_mode and cfg_swap mid-packet are ignored.
REQ-021 packet_count SHALL increment on each accepted tlast beat and wrap from BURST_SIZE-1 to 0.
REQ-022 Each FIFO entry SHALL store data, tlast, and burst_last, where burst_last = tlast && packet_count==BURST_SIZE-1 at acceptance.
REQ-023 Each channel output SHALL present the head of its own FIFO.
- tvalid = FIFO not empty.
- The head pops when tvalid && tready.
- The two channels drain independently.
REQ-024 Latency SHALL be one cycle: a beat accepted at edge N is visible on the channel outputs after edge N and can be popped at edge N+1.
REQ-025 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave its occupancy unchanged.
REQ-026 A push and pop on an empty FIFO SHALL not bypass; the popped beat is never the one being pushed.
REQ-027 Channel outputs SHALL hold stable while tvalid=1 and tready=0.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH.
- A full/empty distinction bit or occupancy counter is required.
- Exactly FIFO_DEPTH entries are usable.

Reset
REQ-029 While sreset=1, the following SHALL hold:
- s_axis_tready=0, i_tvalid=0, q_tvalid=0.
- i_tlast, q_tlast, i_burst_last and q_burst_last = 0.
- packet_count=0, FSM=IDLE, latched cfg=0.
- FIFO pointers cleared.
REQ-030 Reset asserted mid-packet SHALL discard all buffered beats and the partial packet.
- After release, the next accepted beat is treated as the first beat of packet 0.
REQ-031 Data storage contents SHALL not require reset; only valid-related state is reset.

Verification (W=8, FIFO_DEPTH=4, BURST_SIZE=2)
REQ-032 Mode 0, swap 0, tdata=0xB4, tlast=1, both readies 1 -> next cycle I=0xC, Q=0x6, both tlast=1, burst_last=0, packet_count=1.
REQ-033 Mode 1, then mode 1 with swap 1, tdata=0xB4 -> I=0xB, Q=0x4, then I=0x4, Q=0xB.
REQ-034 q_tready=0, i_tready=1, 6 beats offered -> 4 accepted and s_axis_tready=0 after the 4th; I drains all 4; Q holds its first beat stable; raising q_tready releases Q and then accepts the remaining 2.
REQ-035 Toggle cfg_mode on the 2nd beat of a 3-beat packet -> all 3 beats use the mode from beat 1; the next packet uses the new mode.
REQ-036 Four single-beat packets -> burst_last=1 on packets 2 and 4 only; packet_count sequence 0,1,0,1,0.
REQ-037 Assert sreset with 3 beats buffered mid-packet -> both tvalid=0 next cycle; after release, the first beat is packet 0, uses freshly latched cfg, and carries no stale data.
